muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 64: operand and result width and iteration count.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request, sampled on rising clk.
REQ-005 The block SHALL have port funct3, input, 3 bits: operation select; 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have port r1, input, XLEN bits: rs1 operand (multiplicand or dividend).
REQ-007 The block SHALL have port r2, input, XLEN bits: rs2 operand (multiplier or divisor).
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse; result valid.
REQ-010 The block SHALL have port result, output, XLEN bits: registered result.

Function
REQ-011 The block SHALL implement three states: IDLE, CALC and DONE.
REQ-012 The block SHALL accept start only in IDLE or DONE; on an accepting edge it SHALL capture r1, r2 and funct3 and go to CALC.
REQ-013 The block SHALL ignore start while in CALC; it SHALL neither restart nor recapture operands.
REQ-014 The block SHALL not react to operand changes after the accepting edge.
REQ-015 The block SHALL, in CALC, perform exactly XLEN iterations using a counter over 0..XLEN-1; multiply SHALL be radix-2 shift-add, divide SHALL be radix-2 restoring.
REQ-016 The block SHALL move CALC->DONE on the edge that completes iteration XLEN-1.
REQ-017 The block SHALL move DONE->IDLE on the next edge without start, or DONE->CALC on that edge with start.
REQ-018 busy SHALL be high exactly in CALC.
REQ-019 done SHALL be high exactly in DONE.
REQ-020 The block SHALL have fixed latency: for start accepted at edge k, busy is high in cycles k+1..k+XLEN and done is high in cycle k+XLEN+1 (65 for XLEN=64).
REQ-021 Latency SHALL be independent of operand values and of the special cases below.
REQ-022 result SHALL be written only on entry to DONE and SHALL hold until the next entry to DONE.
REQ-023 MUL SHALL return the low XLEN bits of the 2*XLEN product.
REQ-024 MULH, MULHSU and MULHU SHALL return the high XLEN bits with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
REQ-025 For signed operations the block SHALL iterate on magnitudes and negate the final product or quotient per sign rules.
REQ-026 The remainder SHALL take the sign of the dividend, and quotients SHALL truncate toward zero.
REQ-027 For divide by zero (r2=0), DIV and DIVU SHALL return all-ones and REM and REMU SHALL return r1.
REQ-028 For signed overflow (r1=-2^(XLEN-1), r2=-1), DIV SHALL return r1 and REM SHALL return 0.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, counter=0 and clear internal registers, regardless of clk.
REQ-030 A reset asserted mid-operation SHALL abandon the operation with no done pulse; the first start after release SHALL begin a fresh operation.
REQ-031 Reset deassertion SHALL take effect at the next rising clk; start sampled on that edge SHALL be accepted.

Verification
REQ-032 The bench SHALL cover MUL r1=7, r2=0xFFFFFFFFFFFFFFFD: busy for 64 cycles, done in cycle 65, result 0xFFFFFFFFFFFFFFEB.
REQ-033 The bench SHALL cover MULHU r1=r2=0xFFFFFFFFFFFFFFFF -> result 0xFFFFFFFFFFFFFFFE; then MULH with the same operands -> result 0.
REQ-034 The bench SHALL cover DIV r1=100, r2=0 -> result 0xFFFFFFFFFFFFFFFF; then REMU r1=100, r2=0 -> result 0x64; both with latency 65.
REQ-035 The bench SHALL cover DIV r1=0x8000000000000000, r2=0xFFFFFFFFFFFFFFFF -> result 0x8000000000000000; REM with the same operands -> result 0.
REQ-036 The bench SHALL cover DIV r1=-7, r2=2 -> result 0xFFFFFFFFFFFFFFFD; REM -> result 0xFFFFFFFFFFFFFFFF; back-to-back start during DONE is accepted with no IDLE cycle.
REQ-037 The bench SHALL cover start pulses during CALC, which are ignored (result from the original operands, done once); rst_n low at CALC cycle 30 -> busy=0, result=0, no done pulse.

Source files
------------

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Purpose : Iterative radix-2 multiply / restoring divide, fixed XLEN-cycle latency
// Revision: 1.0
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int c_cw = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(XLEN - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]          r_state, w_state_nxt;
  logic [c_cw-1:0]     r_cnt;
  logic [2:0]          r_op;
  logic                r_neg;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_result;

  logic                w_accept, w_last;
  logic                w_s1, w_s2, w_neg1, w_neg2, w_neg_in;
  logic [XLEN-1:0]     w_mag1, w_mag2;
  logic [XLEN:0]       w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0]   w_acc_nxt, w_mul_full;
  logic [XLEN-1:0]     w_div_sel, w_res_nxt;

  assign w_accept = start && (r_state != c_CALC);
  assign w_last   = (r_state == c_CALC) && (r_cnt == c_cnt_last);

  // Operand signedness: DIV/REM signed both, MULH both, MULHSU rs1 only.
  always_comb begin
    w_s1 = 1'b0;
    w_s2 = 1'b0;
    if (funct3[2]) begin
      w_s1 = ~funct3[0];
      w_s2 = ~funct3[0];
    end else begin
      w_s1 = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
      w_s2 = (funct3[1:0] == 2'b01);
    end
    w_neg1 = w_s1 & r1[XLEN-1];
    w_neg2 = w_s2 & r2[XLEN-1];
    w_mag1 = w_neg1 ? -r1 : r1;
    w_mag2 = w_neg2 ? -r2 : r2;
    // A zero divisor must keep the all-ones quotient un-negated.
    if (!funct3[2])     w_neg_in = w_neg1 ^ w_neg2;
    else if (funct3[1]) w_neg_in = w_neg1;
    else                w_neg_in = (w_neg1 ^ w_neg2) && (r2 != '0);
  end

  always_comb begin
    w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shift   = r_acc[2*XLEN-1:XLEN-1];
    w_diff    = w_shift - {1'b0, r_b};
    w_acc_nxt = {w_sum, r_acc[XLEN-1:1]};
    if (r_op[2]) begin
      if (!w_diff[XLEN]) w_acc_nxt = {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
      else               w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    w_mul_full = r_neg ? -w_acc_nxt : w_acc_nxt;
    w_div_sel  = r_op[1] ? w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];
    if (r_op[2])                 w_res_nxt = r_neg ? -w_div_sel : w_div_sel;
    else if (r_op[1:0] == 2'b00) w_res_nxt = w_mul_full[XLEN-1:0];
    else                         w_res_nxt = w_mul_full[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (start) w_state_nxt = c_CALC;
      c_CALC:  if (w_last) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = start ? c_CALC : c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == c_CALC);
    done = (r_state == c_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_op  <= funct3;
      r_neg <= w_neg_in;
      r_b   <= funct3[2] ? w_mag2 : w_mag1;
      r_acc <= {{XLEN{1'b0}}, (funct3[2] ? w_mag1 : w_mag2)};
    end else if (r_state == c_CALC) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc_nxt;
      if (w_last) r_result <= w_res_nxt;
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Purpose : Self-checking bench for muldiv_unit (vector table + scoreboard)
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;

  localparam logic [63:0] c_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_MIN  = 64'h8000_0000_0000_0000;

  logic        clk, rst_n, start;
  logic [2:0]  funct3;
  logic [63:0] r1, r2, result;
  logic        busy, done;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  logic [63:0] sb[$];
  logic [63:0] sb_exp;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[12];

  muldiv_unit #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .r1(r1), .r2(r2), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  q;
    p = '0;
    q = '0;
    case (f)
      3'd0: begin p = {64'b0, a} * {64'b0, b}; q = p[63:0]; end
      3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); q = p[127:64]; end
      3'd2: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); q = p[127:64]; end
      3'd3: begin p = {64'b0, a} * {64'b0, b}; q = p[127:64]; end
      3'd4: q = (b == 0) ? c_ONES : (a == c_MIN && b == c_ONES) ? a : 64'($signed(a) / $signed(b));
      3'd5: q = (b == 0) ? c_ONES : a / b;
      3'd6: q = (b == 0) ? a : (a == c_MIN && b == c_ONES) ? 64'd0 : 64'($signed(a) % $signed(b));
      default: q = (b == 0) ? a : a % b;
    endcase
    return q;
  endfunction

  // Scoreboard: every done pulse consumes exactly one expected result.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done", result);
      end else begin
        sb_exp = sb.pop_front();
        check("result", result, sb_exp);
      end
    end
  end

  // Call aligned to a negedge; operands are scrambled after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] e, input bit push);
    start  = 1'b1;
    funct3 = f;
    r1     = a;
    r2     = b;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    r1     = {$urandom, $urandom};
    r2     = {$urandom, $urandom};
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat   = 0;
    nbusy = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
      if (lat > 200) begin
        checks++;
        errors++;
        $display("FAIL timeout: got no done after %0d cycles expected done at 65", lat);
        break;
      end
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e);
    int lat, nb;
    @(negedge clk);
    issue(f, a, b, e, 1'b1);
    wait_done(lat, nb);
    check("latency", 64'(lat), 64'd65);
    check("busy_cycles", 64'(nb), 64'd64);
    repeat (2) @(negedge clk);
    check("result_hold", result, e);
    check("idle_flags", {62'b0, busy, done}, 64'd0);
  endtask

  initial begin
    int lat, nb, n0;
    logic [63:0] a, b;
    logic [2:0]  f;

    tbl[0]  = '{3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    tbl[1]  = '{3'd3, c_ONES, c_ONES, 64'hFFFF_FFFF_FFFF_FFFE};
    tbl[2]  = '{3'd1, c_ONES, c_ONES, 64'd0};
    tbl[3]  = '{3'd4, 64'd100, 64'd0, c_ONES};
    tbl[4]  = '{3'd7, 64'd100, 64'd0, 64'h64};
    tbl[5]  = '{3'd4, c_MIN, c_ONES, c_MIN};
    tbl[6]  = '{3'd6, c_MIN, c_ONES, 64'd0};
    tbl[7]  = '{3'd2, c_ONES, c_ONES, c_ONES};
    tbl[8]  = '{3'd5, 64'd100, 64'd7, 64'd14};
    tbl[9]  = '{3'd7, 64'd100, 64'd7, 64'd2};
    tbl[10] = '{3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
    tbl[11] = '{3'd0, 64'h1_2345_6789, 64'h1000, 64'h1234_5678_9000};

    rst_n = 1'b0; start = 1'b0; funct3 = '0; r1 = '0; r2 = '0;
    repeat (2) @(negedge clk);
    check("reset_flags", {62'b0, busy, done}, 64'd0);
    check("reset_result", result, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_op(tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp);

    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      b = (i % 4 == 0) ? 64'd0 : (i % 4 == 1) ? {32'b0, $urandom} : {$urandom, $urandom};
      f = 3'(i);
      run_op(f, a, b, model(f, a, b));
    end

    // Back-to-back: REM accepted in the DONE cycle of DIV, no IDLE gap.
    @(negedge clk);
    issue(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1);
    wait_done(lat, nb);
    check("b2b_first_latency", 64'(lat), 64'd65);
    issue(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    @(negedge clk);
    check("b2b_no_idle", {62'b0, busy, done}, 64'd2);
    wait_done(lat, nb);
    check("b2b_second_latency", 64'(lat), 64'd64);

    // Start pulses during CALC are ignored.
    @(negedge clk);
    n0 = n_done;
    issue(3'd0, 64'd12345, 64'd678, 64'd8369910, 1'b1);
    lat = 0;
    nb  = 0;
    forever begin
      @(negedge clk);
      lat++;
      start = (lat == 10 || lat == 40);
      if (busy) nb++;
      if (done || lat > 200) break;
    end
    start = 1'b0;
    check("ign_latency", 64'(lat), 64'd65);
    check("ign_busy_cycles", 64'(nb), 64'd64);
    repeat (3) @(negedge clk);
    check("ign_done_once", 64'(n_done - n0), 64'd1);

    // Reset at CALC cycle 30 abandons the operation.
    @(negedge clk);
    issue(3'd5, 64'd999999, 64'd3, 64'd0, 1'b0);
    repeat (30) @(negedge clk);
    check("pre_reset_busy", {63'b0, busy}, 64'd1);
    n0 = n_done;
    rst_n = 1'b0;
    #1;
    check("rst_flags", {62'b0, busy, done}, 64'd0);
    check("rst_result", result, 64'd0);
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(n_done - n0), 64'd0);
    rst_n = 1'b1;
    issue(3'd0, 64'd6, 64'd7, 64'd42, 1'b1);
    wait_done(lat, nb);
    check("post_rst_latency", 64'(lat), 64'd65);
    repeat (2) @(negedge clk);
    check("post_rst_done_once", 64'(n_done - n0), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
